// File: rtl/ahbl_defs.sv
// Shared AHB-Lite definitions: HTRANS codes and the
// data-phase owner encoding used by the AHB-Lite blocks.
package ahbl_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  function automatic logic ahb_req(
    input logic       sel,
    input logic [1:0] trans,
    input logic       rdy
  );
    return sel & trans[1] & rdy;
  endfunction

endpackage

// File: rtl/ahbl_req_hold.sv
// Per-master hold register for an address phase that could not
// be forwarded; pending is derived from the held HTRANS.
module ahbl_req_hold
  import ahbl_defs::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          i_capture,
  input  logic          i_clear,
  input  logic [AW-1:0] i_addr,
  input  logic [1:0]    i_trans,
  input  logic [2:0]    i_size,
  input  logic          i_write,
  output logic          o_pend,
  output logic [AW-1:0] o_addr,
  output logic [2:0]    o_size,
  output logic          o_write
);

  logic [AW-1:0] r_addr;
  logic [1:0]    r_trans;
  logic [2:0]    r_size;
  logic          r_write;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_trans <= HTRANS_IDLE;
      r_size  <= '0;
      r_write <= 1'b0;
    end else if (i_capture) begin
      r_addr  <= i_addr;
      r_trans <= i_trans;
      r_size  <= i_size;
      r_write <= i_write;
    end else if (i_clear) begin
      r_trans <= HTRANS_IDLE;
    end
  end

  // Only NONSEQ/SEQ are ever captured, so bit 1 marks a held request
  assign o_pend  = r_trans[1];
  assign o_addr  = r_addr;
  assign o_size  = r_size;
  assign o_write = r_write;

endmodule

// File: rtl/ahbl_rom_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single ROM slave:
// zero-latency pass-through for winners, hold-and-replay for losers.
module ahbl_rom_arbiter
  import ahbl_defs::*;
#(
  parameter int AW    = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          M0_HSEL,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic [2:0]    M0_HSIZE,
  input  logic          M0_HWRITE,
  input  logic [31:0]   M0_HWDATA,
  output logic          M0_HREADY,
  output logic [31:0]   M0_HRDATA,
  input  logic          M1_HSEL,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic [2:0]    M1_HSIZE,
  input  logic          M1_HWRITE,
  input  logic [31:0]   M1_HWDATA,
  output logic          M1_HREADY,
  output logic [31:0]   M1_HRDATA,
  output logic          S_HSEL,
  output logic [AW-1:0] S_HADDR,
  output logic [1:0]    S_HTRANS,
  output logic [2:0]    S_HSIZE,
  output logic          S_HWRITE,
  output logic [31:0]   S_HWDATA,
  output logic          S_HREADY,
  input  logic          S_HREADYOUT,
  input  logic [31:0]   S_HRDATA
);

  owner_e        r_owner;
  owner_e        w_owner_nxt;
  logic          r_last_m1;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_size;
  logic          r_write;

  logic          w_free;
  logic          w_l0;
  logic          w_l1;
  logic          w_p0;
  logic          w_p1;
  logic          w_g0;
  logic          w_g1;
  logic          w_tie_m1;
  logic [AW-1:0] w_h0_addr;
  logic [AW-1:0] w_h1_addr;
  logic [2:0]    w_h0_size;
  logic [2:0]    w_h1_size;
  logic          w_h0_write;
  logic          w_h1_write;

  assign w_l0 = ahb_req(M0_HSEL, M0_HTRANS, M0_HREADY);
  assign w_l1 = ahb_req(M1_HSEL, M1_HTRANS, M1_HREADY);

  // Gated by reset so nothing reaches the slave while in reset
  assign w_free = HRESETn &
                  ((r_owner == OWN_NONE) | S_HREADYOUT);

  assign w_tie_m1 = RR_EN && !r_last_m1;

  ahbl_req_hold #(.AW(AW)) u_hold0 (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .i_capture (w_l0 & ~w_g0),
    .i_clear   (w_p0 & w_g0),
    .i_addr    (M0_HADDR),
    .i_trans   (M0_HTRANS),
    .i_size    (M0_HSIZE),
    .i_write   (M0_HWRITE),
    .o_pend    (w_p0),
    .o_addr    (w_h0_addr),
    .o_size    (w_h0_size),
    .o_write   (w_h0_write)
  );

  ahbl_req_hold #(.AW(AW)) u_hold1 (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .i_capture (w_l1 & ~w_g1),
    .i_clear   (w_p1 & w_g1),
    .i_addr    (M1_HADDR),
    .i_trans   (M1_HTRANS),
    .i_size    (M1_HSIZE),
    .i_write   (M1_HWRITE),
    .o_pend    (w_p1),
    .o_addr    (w_h1_addr),
    .o_size    (w_h1_size),
    .o_write   (w_h1_write)
  );

  // Held requests outrank live ones; ties go by RR or to M0
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (w_free) begin
      if (w_p0 & w_p1) begin
        w_g1 = w_tie_m1;
        w_g0 = ~w_tie_m1;
      end else if (w_p0 | w_p1) begin
        w_g1 = w_p1;
        w_g0 = w_p0;
      end else if (w_l0 & w_l1) begin
        w_g1 = w_tie_m1;
        w_g0 = ~w_tie_m1;
      end else begin
        w_g1 = w_l1;
        w_g0 = w_l0;
      end
    end
  end

  always_comb begin
    S_HSEL   = w_g0 | w_g1;
    S_HTRANS = HTRANS_IDLE;
    S_HADDR  = r_addr;
    S_HSIZE  = r_size;
    S_HWRITE = r_write;
    if (w_g0) begin
      S_HTRANS = w_p0 ? HTRANS_NONSEQ : M0_HTRANS;
      S_HADDR  = w_p0 ? w_h0_addr : M0_HADDR;
      S_HSIZE  = w_p0 ? w_h0_size : M0_HSIZE;
      S_HWRITE = w_p0 ? w_h0_write : M0_HWRITE;
    end else if (w_g1) begin
      S_HTRANS = w_p1 ? HTRANS_NONSEQ : M1_HTRANS;
      S_HADDR  = w_p1 ? w_h1_addr : M1_HADDR;
      S_HSIZE  = w_p1 ? w_h1_size : M1_HSIZE;
      S_HWRITE = w_p1 ? w_h1_write : M1_HWRITE;
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    if (w_free) begin
      if (w_g0)      w_owner_nxt = OWN_M0;
      else if (w_g1) w_owner_nxt = OWN_M1;
      else           w_owner_nxt = OWN_NONE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner   <= OWN_NONE;
      r_last_m1 <= 1'b1;
      r_addr    <= '0;
      r_size    <= '0;
      r_write   <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      if (w_g0 | w_g1) begin
        r_last_m1 <= w_g1;
        r_addr    <= S_HADDR;
        r_size    <= S_HSIZE;
        r_write   <= S_HWRITE;
      end
    end
  end

  always_comb begin
    S_HWDATA = '0;
    unique case (r_owner)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: S_HWDATA = '0;
    endcase
  end

  assign S_HREADY  = (r_owner == OWN_NONE) ? 1'b1 : S_HREADYOUT;

  assign M0_HREADY = (r_owner == OWN_M0) ? S_HREADYOUT : ~w_p0;
  assign M1_HREADY = (r_owner == OWN_M1) ? S_HREADYOUT : ~w_p1;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

endmodule

// File: tb/tb_ahbl_rom_arbiter.sv
// Directed bench for ahbl_rom_arbiter: an RR instance and a
// fixed-priority instance share master stimulus, each with a ROM.
module tb_ahbl_rom_arbiter;
  import ahbl_defs::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        M0_HSEL, M1_HSEL;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HWRITE, M1_HWRITE;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        S_HREADYOUT;

  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        S_HSEL, S_HWRITE, S_HREADY;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;

  logic        f_M0_HREADY, f_M1_HREADY;
  logic [31:0] f_M0_HRDATA, f_M1_HRDATA;
  logic        f_S_HSEL, f_S_HWRITE, f_S_HREADY;
  logic [31:0] f_S_HADDR, f_S_HWDATA, f_S_HRDATA;
  logic [1:0]  f_S_HTRANS;
  logic [2:0]  f_S_HSIZE;

  logic [31:0] r_dp_addr = '0;
  logic [31:0] f_dp_addr = '0;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 HCLK = ~HCLK;

  // ROM: word at address a reads as ~a
  always @(posedge HCLK) if (S_HREADY) r_dp_addr <= S_HADDR;
  always @(posedge HCLK) if (f_S_HREADY) f_dp_addr <= f_S_HADDR;
  assign S_HRDATA   = ~r_dp_addr;
  assign f_S_HRDATA = ~f_dp_addr;

  ahbl_rom_arbiter #(.AW(32), .RR_EN(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
    .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS),
    .S_HSIZE(S_HSIZE), .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA),
    .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
  );

  ahbl_rom_arbiter #(.AW(32), .RR_EN(1'b0)) dut_fix (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(f_M0_HREADY), .M0_HRDATA(f_M0_HRDATA),
    .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(f_M1_HREADY), .M1_HRDATA(f_M1_HRDATA),
    .S_HSEL(f_S_HSEL), .S_HADDR(f_S_HADDR), .S_HTRANS(f_S_HTRANS),
    .S_HSIZE(f_S_HSIZE), .S_HWRITE(f_S_HWRITE), .S_HWDATA(f_S_HWDATA),
    .S_HREADY(f_S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(f_S_HRDATA)
  );

  task automatic drv0(input logic [31:0] a, input logic [1:0] t, input logic w);
    M0_HSEL = 1'b1; M0_HADDR = a; M0_HTRANS = t;
    M0_HSIZE = 3'b010; M0_HWRITE = w;
  endtask

  task automatic drv1(input logic [31:0] a, input logic [1:0] t, input logic w);
    M1_HSEL = 1'b1; M1_HADDR = a; M1_HTRANS = t;
    M1_HSIZE = 3'b010; M1_HWRITE = w;
  endtask

  task automatic idle_all();
    drv0(32'h0, HTRANS_IDLE, 1'b0);
    drv1(32'h0, HTRANS_IDLE, 1'b0);
    M0_HWDATA = '0; M1_HWDATA = '0;
    S_HREADYOUT = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    idle_all();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    idle_all();
    drv0(32'h44, HTRANS_NONSEQ, 1'b0);
    #1;
    tot_cnt++; if (S_HSEL !== 1'b0) $display("FAIL rst_hsel: got %b want 0", S_HSEL); else pass_cnt++;
    tot_cnt++; if (S_HTRANS !== HTRANS_IDLE) $display("FAIL rst_htrans: got %b want 00", S_HTRANS); else pass_cnt++;
    tot_cnt++; if (S_HADDR !== 32'h0) $display("FAIL rst_haddr: got %h want 0", S_HADDR); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b1) $display("FAIL rst_m0rdy: got %b want 1", M0_HREADY); else pass_cnt++;
    tot_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL rst_m1rdy: got %b want 1", M1_HREADY); else pass_cnt++;
    @(negedge HCLK);
    idle_all();
    HRESETn = 1'b1;
    @(negedge HCLK);
    drv0(32'h44, HTRANS_NONSEQ, 1'b0);
    #1;
    tot_cnt++; if (S_HADDR !== 32'h44) $display("FAIL rst_first_arb: got %h want 44", S_HADDR); else pass_cnt++;
    @(negedge HCLK);
    idle_all();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge HCLK); drv0(32'h0, HTRANS_NONSEQ, 1'b0); #1;
    tot_cnt++; if (S_HADDR !== 32'h0 || S_HTRANS !== HTRANS_NONSEQ) $display("FAIL single_a0: got %h/%b want 0/10", S_HADDR, S_HTRANS); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b1) $display("FAIL single_rdy0: got %b want 1", M0_HREADY); else pass_cnt++;
    @(negedge HCLK); drv0(32'h4, HTRANS_SEQ, 1'b0); #1;
    tot_cnt++; if (S_HADDR !== 32'h4 || S_HTRANS !== HTRANS_SEQ) $display("FAIL single_a4: got %h/%b want 4/11", S_HADDR, S_HTRANS); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== 32'hFFFFFFFF) $display("FAIL single_d0: got %b/%h want 1/ffffffff", M0_HREADY, M0_HRDATA); else pass_cnt++;
    @(negedge HCLK); drv0(32'h8, HTRANS_SEQ, 1'b0); #1;
    tot_cnt++; if (S_HADDR !== 32'h8) $display("FAIL single_a8: got %h want 8", S_HADDR); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== 32'hFFFFFFFB) $display("FAIL single_d4: got %b/%h want 1/fffffffb", M0_HREADY, M0_HRDATA); else pass_cnt++;
    @(negedge HCLK); drv0(32'h0, HTRANS_IDLE, 1'b0); #1;
    tot_cnt++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== 32'hFFFFFFF7) $display("FAIL single_d8: got %b/%h want 1/fffffff7", M0_HREADY, M0_HRDATA); else pass_cnt++;
    tot_cnt++; if (S_HSEL !== 1'b0 || S_HTRANS !== HTRANS_IDLE) $display("FAIL single_idle: got %b/%b want 0/00", S_HSEL, S_HTRANS); else pass_cnt++;
    tot_cnt++; if (S_HADDR !== 32'h8) $display("FAIL single_addr_hold: got %h want 8", S_HADDR); else pass_cnt++;
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge HCLK);
    drv0(32'h10, HTRANS_NONSEQ, 1'b0);
    drv1(32'h20, HTRANS_NONSEQ, 1'b0);
    #1;
    tot_cnt++; if (S_HADDR !== 32'h10 || S_HSEL !== 1'b1) $display("FAIL col_t_addr: got %h/%b want 10/1", S_HADDR, S_HSEL); else pass_cnt++;
    tot_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL col_t_m1rdy: got %b want 1", M1_HREADY); else pass_cnt++;
    @(negedge HCLK); idle_all(); #1;
    tot_cnt++; if (S_HADDR !== 32'h20 || S_HTRANS !== HTRANS_NONSEQ) $display("FAIL col_t1_addr: got %h/%b want 20/10", S_HADDR, S_HTRANS); else pass_cnt++;
    tot_cnt++; if (M1_HREADY !== 1'b0) $display("FAIL col_t1_m1rdy: got %b want 0", M1_HREADY); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== 32'hFFFFFFEF) $display("FAIL col_t1_m0data: got %b/%h want 1/ffffffef", M0_HREADY, M0_HRDATA); else pass_cnt++;
    @(negedge HCLK); #1;
    tot_cnt++; if (M1_HREADY !== 1'b1 || M1_HRDATA !== 32'hFFFFFFDF) $display("FAIL col_t2_m1data: got %b/%h want 1/ffffffdf", M1_HREADY, M1_HRDATA); else pass_cnt++;
    tot_cnt++; if (S_HSEL !== 1'b0) $display("FAIL col_t2_idle: got %b want 0", S_HSEL); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_a [6] = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    int c0 = 0;
    int c1 = 0;
    logic h0, h1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      drv0(32'h100 + 32'(4 * c0), HTRANS_NONSEQ, 1'b0);
      drv1(32'h200 + 32'(4 * c1), HTRANS_NONSEQ, 1'b0);
      #1;
      tot_cnt++; if (S_HADDR !== exp_a[k] || S_HTRANS !== HTRANS_NONSEQ) $display("FAIL rr_grant%0d: got %h/%b want %h/10", k, S_HADDR, S_HTRANS, exp_a[k]); else pass_cnt++;
      h0 = M0_HREADY;
      h1 = M1_HREADY;
      if (h0) c0++;
      if (h1) c1++;
    end
    @(negedge HCLK); idle_all();
  endtask

  task automatic test_fixed_vs_rr();
    do_reset();
    @(negedge HCLK); drv0(32'h40, HTRANS_NONSEQ, 1'b0);
    @(negedge HCLK); idle_all();
    @(negedge HCLK);
    drv0(32'h50, HTRANS_NONSEQ, 1'b0);
    drv1(32'h60, HTRANS_NONSEQ, 1'b0);
    #1;
    tot_cnt++; if (S_HADDR !== 32'h60) $display("FAIL rr_tie_addr: got %h want 60", S_HADDR); else pass_cnt++;
    tot_cnt++; if (f_S_HADDR !== 32'h50) $display("FAIL fix_tie_addr: got %h want 50", f_S_HADDR); else pass_cnt++;
    @(negedge HCLK); idle_all(); #1;
    tot_cnt++; if (S_HADDR !== 32'h50 || M0_HREADY !== 1'b0) $display("FAIL rr_tie_held: got %h/%b want 50/0", S_HADDR, M0_HREADY); else pass_cnt++;
    tot_cnt++; if (f_S_HADDR !== 32'h60 || f_M1_HREADY !== 1'b0) $display("FAIL fix_tie_held: got %h/%b want 60/0", f_S_HADDR, f_M1_HREADY); else pass_cnt++;
  endtask

  task automatic test_fixed_no_starve();
    do_reset();
    @(negedge HCLK);
    drv0(32'h300, HTRANS_NONSEQ, 1'b0);
    drv1(32'h80, HTRANS_NONSEQ, 1'b0);
    #1;
    tot_cnt++; if (f_S_HADDR !== 32'h300) $display("FAIL fix_ns_c0: got %h want 300", f_S_HADDR); else pass_cnt++;
    @(negedge HCLK);
    drv0(32'h304, HTRANS_NONSEQ, 1'b0);
    drv1(32'h0, HTRANS_IDLE, 1'b0);
    #1;
    tot_cnt++; if (f_S_HADDR !== 32'h80 || f_M1_HREADY !== 1'b0) $display("FAIL fix_ns_c1: got %h/%b want 80/0", f_S_HADDR, f_M1_HREADY); else pass_cnt++;
    @(negedge HCLK);
    drv0(32'h308, HTRANS_NONSEQ, 1'b0);
    #1;
    tot_cnt++; if (f_S_HADDR !== 32'h304) $display("FAIL fix_ns_c2: got %h want 304", f_S_HADDR); else pass_cnt++;
    tot_cnt++; if (f_M1_HREADY !== 1'b1 || f_M1_HRDATA !== 32'hFFFFFF7F) $display("FAIL fix_ns_m1data: got %b/%h want 1/ffffff7f", f_M1_HREADY, f_M1_HRDATA); else pass_cnt++;
    @(negedge HCLK); idle_all();
  endtask

  task automatic test_wait_state();
    do_reset();
    @(negedge HCLK); drv0(32'h90, HTRANS_NONSEQ, 1'b0); #1;
    tot_cnt++; if (S_HADDR !== 32'h90) $display("FAIL ws_c0_addr: got %h want 90", S_HADDR); else pass_cnt++;
    @(negedge HCLK);
    drv0(32'h0, HTRANS_IDLE, 1'b0);
    drv1(32'hA0, HTRANS_NONSEQ, 1'b0);
    S_HREADYOUT = 1'b0;
    #1;
    tot_cnt++; if (S_HSEL !== 1'b0 || S_HTRANS !== HTRANS_IDLE) $display("FAIL ws_c1_noxfer: got %b/%b want 0/00", S_HSEL, S_HTRANS); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b0 || S_HREADY !== 1'b0) $display("FAIL ws_c1_stall: got %b/%b want 0/0", M0_HREADY, S_HREADY); else pass_cnt++;
    @(negedge HCLK); drv1(32'h0, HTRANS_IDLE, 1'b0); #1;
    tot_cnt++; if (M1_HREADY !== 1'b0 || S_HSEL !== 1'b0) $display("FAIL ws_c2_held: got %b/%b want 0/0", M1_HREADY, S_HSEL); else pass_cnt++;
    @(negedge HCLK); S_HREADYOUT = 1'b1; #1;
    tot_cnt++; if (S_HSEL !== 1'b1 || S_HADDR !== 32'hA0 || S_HTRANS !== HTRANS_NONSEQ) $display("FAIL ws_c3_fwd: got %b/%h/%b want 1/a0/10", S_HSEL, S_HADDR, S_HTRANS); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== 32'hFFFFFF6F) $display("FAIL ws_c3_m0data: got %b/%h want 1/ffffff6f", M0_HREADY, M0_HRDATA); else pass_cnt++;
    tot_cnt++; if (M1_HREADY !== 1'b0) $display("FAIL ws_c3_m1rdy: got %b want 0", M1_HREADY); else pass_cnt++;
    @(negedge HCLK); #1;
    tot_cnt++; if (M1_HREADY !== 1'b1 || M1_HRDATA !== 32'hFFFFFF5F) $display("FAIL ws_c4_m1data: got %b/%h want 1/ffffff5f", M1_HREADY, M1_HRDATA); else pass_cnt++;
  endtask

  task automatic test_write();
    do_reset();
    @(negedge HCLK);
    drv0(32'h10, HTRANS_NONSEQ, 1'b0);
    drv1(32'h30, HTRANS_NONSEQ, 1'b1);
    #1;
    tot_cnt++; if (S_HADDR !== 32'h10 || S_HWRITE !== 1'b0) $display("FAIL wr_c0: got %h/%b want 10/0", S_HADDR, S_HWRITE); else pass_cnt++;
    @(negedge HCLK);
    drv0(32'h0, HTRANS_IDLE, 1'b0);
    drv1(32'h0, HTRANS_IDLE, 1'b0);
    M0_HWDATA = 32'h11111111;
    M1_HWDATA = 32'hDEADBEEF;
    #1;
    tot_cnt++; if (S_HADDR !== 32'h30 || S_HWRITE !== 1'b1) $display("FAIL wr_c1_fwd: got %h/%b want 30/1", S_HADDR, S_HWRITE); else pass_cnt++;
    tot_cnt++; if (S_HWDATA !== 32'h11111111) $display("FAIL wr_c1_wdata: got %h want 11111111", S_HWDATA); else pass_cnt++;
    @(negedge HCLK); #1;
    tot_cnt++; if (S_HWDATA !== 32'hDEADBEEF || S_HWRITE !== 1'b1) $display("FAIL wr_c2_wdata: got %h/%b want deadbeef/1", S_HWDATA, S_HWRITE); else pass_cnt++;
    tot_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL wr_c2_m1rdy: got %b want 1", M1_HREADY); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge HCLK);
    drv0(32'h10, HTRANS_NONSEQ, 1'b0);
    drv1(32'h20, HTRANS_NONSEQ, 1'b0);
    @(negedge HCLK); idle_all(); #1;
    tot_cnt++; if (M1_HREADY !== 1'b0) $display("FAIL rmid_pend: got %b want 0", M1_HREADY); else pass_cnt++;
    HRESETn = 1'b0;
    #1;
    tot_cnt++; if (S_HSEL !== 1'b0 || S_HTRANS !== HTRANS_IDLE) $display("FAIL rmid_idle: got %b/%b want 0/00", S_HSEL, S_HTRANS); else pass_cnt++;
    tot_cnt++; if (M0_HREADY !== 1'b1 || M1_HREADY !== 1'b1) $display("FAIL rmid_rdy: got %b/%b want 1/1", M0_HREADY, M1_HREADY); else pass_cnt++;
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK); #1;
      tot_cnt++; if (S_HSEL !== 1'b0 || S_HTRANS !== HTRANS_IDLE) $display("FAIL rmid_after%0d: got %b/%b want 0/00", k, S_HSEL, S_HTRANS); else pass_cnt++;
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_collision();
    test_round_robin();
    test_fixed_vs_rr();
    test_fixed_no_starve();
    test_wait_state();
    test_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/ahbl_rom_arbiter.md
AHBL_ROM_ARBITER -- requirements
Module: ahbl_rom_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with M0 highest.
REQ-003 SHALL have port HCLK, input, 1, clock; and port HRESETn, input, 1, reset (asynchronous, active-low).
REQ-004 SHALL have, for each m in {0,1}, master-side inputs Mm_HSEL 1, Mm_HADDR AW, Mm_HTRANS 2, Mm_HSIZE 3, Mm_HWRITE 1 and Mm_HWDATA 32; M0 is the CPU fetch port, M1 is the weight-loader port.
REQ-005 SHALL have, for each m, master-side outputs Mm_HREADY 1 (transfer done / stall) and Mm_HRDATA 32.
REQ-006 SHALL have slave-side outputs S_HSEL 1, S_HADDR AW, S_HTRANS 2, S_HSIZE 3, S_HWRITE 1, S_HWDATA 32 and S_HREADY 1.
REQ-007 SHALL have slave-side inputs S_HREADYOUT 1 and S_HRDATA 32.

Function
REQ-008 A request from master m SHALL be Mm_HSEL=1 and Mm_HTRANS[1]=1 while Mm_HREADY=1; IDLE/BUSY transfers SHALL never be forwarded.
REQ-009 The slave address phase SHALL be free when the slave has no data phase or S_HREADYOUT=1.
REQ-010 Arbitration SHALL occur in every cycle where the slave address phase is free.
REQ-011 Candidates SHALL be held (pending) requests and live requests; any pending request SHALL win over every live request.
REQ-012 Between two candidates of equal class: if RR_EN=1, the master not granted last SHALL win; if RR_EN=0, M0 SHALL win.
REQ-013 A live request that wins SHALL be driven to the slave in the same cycle, giving zero added latency.
REQ-014 A live request that loses, or arrives while the address phase is not free, SHALL be captured into that master's hold register (addr, trans, size, write).
REQ-015 The master's Mm_HREADY SHALL then be 0 from the next cycle until its forwarded data phase completes.
REQ-016 A held request SHALL be forwarded as NONSEQ, regardless of its original SEQ/NONSEQ type.
REQ-017 When a held request is granted, its hold register SHALL clear.
REQ-018 A data-phase owner register {NONE, M0, M1} SHALL load the grantee on each free address phase, or NONE if nothing is granted.
REQ-019 S_HWDATA SHALL mux from the data-phase owner's Mm_HWDATA.
REQ-020 The owner SHALL receive Mm_HRDATA=S_HRDATA and Mm_HREADY=S_HREADYOUT.
REQ-021 A non-owner master with nothing held SHALL see Mm_HREADY=1.
REQ-022 Mm_HRDATA SHALL be S_HRDATA at all times; masters sample it only when their Mm_HREADY=1.
REQ-023 S_HREADY SHALL equal S_HREADYOUT when a data phase is in progress, else 1.
REQ-024 S_HSEL SHALL be 1 only when a request is granted; otherwise S_HTRANS=IDLE and S_HSEL=0.
REQ-025 When nothing is granted, the S_HADDR, S_HSIZE and S_HWRITE values are don't-care, but SHALL be held at their last values.
REQ-026 If both masters request simultaneously with ROM zero-wait, the loser's data SHALL be delivered exactly 1 cycle later than the winner's.
REQ-027 Worst-case wait for any request SHALL be 2 slave transfers.
REQ-028 A master SHALL never have more than one held request; this follows because its Mm_HREADY is low while it holds one.
REQ-029 The last-grant flag SHALL update only on an actual grant.

Reset
REQ-030 On HRESETn=0, asynchronously: hold registers cleared, owner=NONE, last-grant=M1 (so M0 wins the first tie).
REQ-031 Output values during and after reset SHALL be: Mm_HREADY=1, S_HSEL=0, S_HTRANS=IDLE, S_HADDR=0.
REQ-032 Reset asserted mid-transfer SHALL discard held and in-flight requests without emitting any slave transfer.
REQ-033 The first arbitration SHALL be in the first HCLK edge after deassertion.

Structure
REQ-034 Owner encoding (NONE=2'b00, M0=2'b01, M1=2'b10) and the HTRANS codes SHALL be defined in the shared ahbl_defs header, used by all AHB-Lite blocks.
REQ-035 The per-master hold register plus its pending flag SHALL be the sub-module ahbl_req_hold, instantiated twice; arbitration, owner register and muxes SHALL be in the top.
REQ-036 No combinational path from S_HREADYOUT to S_HTRANS SHALL exist except through the free-phase grant, as required by AHB-Lite.

Verification
REQ-037 Reset: assert HRESETn=0 mid-burst -> S_HTRANS=IDLE, M0_HREADY=M1_HREADY=1, no slave transfer after release until a new request.
REQ-038 Single master: M0 reads 0x0000_0000, 0x4, 0x8 back-to-back -> forwarded same cycle, data correct next cycle, M0_HREADY never 0.
REQ-039 Collision: M0 and M1 NONSEQ at cycle t (addr 0x10, 0x20) -> S_HADDR=0x10 at t, 0x20 at t+1; M1_HREADY=0 at t+1, 1 at t+2 with ROM[0x20] data.
REQ-040 Round-robin: both masters stream continuously -> grants alternate M0, M1, M0, ...; with RR_EN=0 and M0 continuous -> M1 stalls only 1 transfer per held request, never starves.
REQ-041 Wait-state slave: S_HREADYOUT=0 for 2 cycles during M0 data phase while M1 requests -> M1 held, forwarded in the cycle S_HREADYOUT returns 1, M1_HREADY low throughout.
REQ-042 Write pass-through: M1 write to 0x30 with HWDATA=0xDEADBEEF while held -> S_HWRITE=1 and S_HWDATA=0xDEADBEEF during the forwarded data phase.
